// File: rtl/rr_arb_pkg.sv
// Shared constants for the 2:1 round-robin arbiter: default channel width and
// the encodings of the downstream mux select.
package rr_arb_pkg;
  localparam int WIDTH_DEF = 8;
  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;
endpackage

// File: rtl/rr_grant2.sv
// Two-requester priority decision: a lone requester always wins, and on a tie
// the pointer picks the winner. The grant is one-hot or zero.
module rr_grant2
  import rr_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic [1:0] o_gnt
);
  always_comb begin
    o_gnt    = 2'b00;
    o_gnt[0] = i_req[0] & (~i_req[1] | (i_prio == SEL_IN1));
    o_gnt[1] = i_req[1] & (~i_req[0] | (i_prio == SEL_IN2));
  end
endmodule

// File: rtl/rr_arb21.sv
// 2:1 round-robin arbiter with a single registered output slot. Full throughput
// when downstream is ready; the pointer flips to the other channel after a grant.
module rr_arb21
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  logic [WIDTH-1:0] in2_data,
  output logic             in2_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel
);
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_sel;
  logic             r_prio;
  logic [1:0]       w_gnt;
  logic             w_free;
  logic             w_acc1;
  logic             w_acc2;

  rr_grant2 u_grant (
    .i_req  ({in2_valid, in1_valid}),
    .i_prio (r_prio),
    .o_gnt  (w_gnt)
  );

  // Readiness never looks at payload, only at grant and slot state.
  assign w_free    = ~r_out_valid | out_ready;
  assign in1_ready = w_gnt[0] & w_free & ~rst;
  assign in2_ready = w_gnt[1] & w_free & ~rst;
  assign w_acc1    = in1_ready & in1_valid;
  assign w_acc2    = in2_ready & in2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sel       <= SEL_IN1;
      r_prio      <= SEL_IN1;
    end else if (w_acc1 | w_acc2) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_acc2 ? in2_data : in1_data;
      r_sel       <= w_acc2 ? SEL_IN2 : SEL_IN1;
      r_prio      <= w_acc2 ? SEL_IN1 : SEL_IN2;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sel       = r_sel;
endmodule
